// File: rtl/netbus_tx5_if.sv
// NetBus flit link: one flit bus with valid/ready handshake.
// master drives data/valid, slave drives ready.
interface netbus_tx5_if #(
  parameter int unsigned FW = 50
);
  logic [FW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/netbus_tx5.sv
// NetBus 1-to-5 frame distributor: routes whole frames by the header dest field into per-port 2-entry buffers.
// Optional macro NETBUS_TX_DROP_CNT_EN adds DROP_CNT/DROP_CLR (count of discarded frames).
module netbus_tx5 #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEST_LSB   = 1
) (
  input  logic             WCLK,
  input  logic             RESETn,
  netbus_tx5_if.slave      w,
  netbus_tx5_if.master     t0,
  netbus_tx5_if.master     t1,
  netbus_tx5_if.master     t2,
  netbus_tx5_if.master     t3,
  netbus_tx5_if.master     t4
`ifdef NETBUS_TX_DROP_CNT_EN
  ,
  output logic [15:0]      DROP_CNT,
  input  logic [0:0]       DROP_CLR
`endif
);

  localparam int unsigned FW = DATA_WIDTH * 9 + 14;
  localparam int unsigned NP = 5;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t          r_state;
  logic [2:0]      r_cur;
  logic [FW-1:0]   r_e0 [NP];
  logic [FW-1:0]   r_e1 [NP];
  logic [1:0]      r_cnt [NP];
  logic [NP-1:0]   r_vld;

  logic [FW-1:0]   w_nxt_e0 [NP];
  logic [FW-1:0]   w_nxt_e1 [NP];
  logic [1:0]      w_nxt_cnt [NP];
  logic [NP-1:0]   w_tready;
  logic [NP-1:0]   w_full;
  logic [7:0]      w_room;
  logic [2:0]      w_dest;
  logic            w_dest_ok;
  logic            w_last;
  logic [2:0]      w_port;
  logic            w_fwd;
  logic            w_ready_c;
  logic            w_acc;
  logic [NP-1:0]   w_push;
  logic [NP-1:0]   w_pop;

  assign w_tready  = {t4.ready, t3.ready, t2.ready, t1.ready, t0.ready};
  assign w_dest    = w.data[DEST_LSB +: 3];
  assign w_dest_ok = (w_dest < 3'd5);
  assign w_last    = w.data[0];

  // A full buffer can still take a flit when its head leaves this cycle
  always_comb begin
    w_full = '0;
    for (int k = 0; k < NP; k++) w_full[k] = (r_cnt[k] == 2'd2);
  end
  assign w_room = {3'b000, ~w_full | w_tready};

  // Ready depends only on state, header dest and port room, never on valid
  always_comb begin
    w_port    = r_cur;
    w_fwd     = 1'b0;
    w_ready_c = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_port    = w_dest;
        w_fwd     = w_dest_ok;
        w_ready_c = w_dest_ok ? w_room[w_dest] : 1'b1;
      end
      S_FWD: begin
        w_fwd     = 1'b1;
        w_ready_c = w_room[r_cur];
      end
      default: ;
    endcase
    w_ready_c = w_ready_c & RESETn;
  end

  assign w.ready = w_ready_c;
  assign w_acc   = w.valid & w_ready_c;

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int k = 0; k < NP; k++) begin
      w_push[k] = w_acc & w_fwd & (w_port == 3'(k));
      w_pop[k]  = r_vld[k] & w_tready[k];
    end
  end

  // Two-entry buffer: e0 is always the head so TDATA comes straight from a register
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      w_nxt_e0[k]  = r_e0[k];
      w_nxt_e1[k]  = r_e1[k];
      w_nxt_cnt[k] = r_cnt[k];
      case ({w_push[k], w_pop[k]})
        2'b10: begin
          if (r_cnt[k] == 2'd0) w_nxt_e0[k] = w.data;
          else                  w_nxt_e1[k] = w.data;
          w_nxt_cnt[k] = r_cnt[k] + 2'd1;
        end
        2'b01: begin
          w_nxt_e0[k]  = r_e1[k];
          w_nxt_cnt[k] = r_cnt[k] - 2'd1;
        end
        2'b11: begin
          if (r_cnt[k] == 2'd1) begin
            w_nxt_e0[k] = w.data;
          end else begin
            w_nxt_e0[k] = r_e1[k];
            w_nxt_e1[k] = w.data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge WCLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int k = 0; k < NP; k++) begin
        r_e0[k]  <= '0;
        r_e1[k]  <= '0;
        r_cnt[k] <= '0;
      end
      r_vld <= '0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        r_e0[k]  <= w_nxt_e0[k];
        r_e1[k]  <= w_nxt_e1[k];
        r_cnt[k] <= w_nxt_cnt[k];
        r_vld[k] <= (w_nxt_cnt[k] != 2'd0);
      end
    end
  end

  // Frame tracking: header picks the port (or drop), last flag closes the frame
  always_ff @(posedge WCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (w_dest_ok) begin
            r_cur <= w_dest;
            if (!w_last) r_state <= S_FWD;
          end else if (!w_last) begin
            r_state <= S_DROP;
          end
        end
        S_FWD:   if (w_last) r_state <= S_IDLE;
        S_DROP:  if (w_last) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign t0.data = r_e0[0];  assign t0.valid = r_vld[0];
  assign t1.data = r_e0[1];  assign t1.valid = r_vld[1];
  assign t2.data = r_e0[2];  assign t2.valid = r_vld[2];
  assign t3.data = r_e0[3];  assign t3.valid = r_vld[3];
  assign t4.data = r_e0[4];  assign t4.valid = r_vld[4];

`ifdef NETBUS_TX_DROP_CNT_EN
  logic        w_drop_hdr;
  logic [15:0] r_drop_cnt;

  assign w_drop_hdr = w_acc & (r_state == S_IDLE) & ~w_dest_ok;

  // Saturating count of discarded frames; clear has priority
  always_ff @(posedge WCLK or negedge RESETn) begin
    if (!RESETn)                               r_drop_cnt <= '0;
    else if (DROP_CLR[0])                      r_drop_cnt <= '0;
    else if (w_drop_hdr && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign DROP_CNT = r_drop_cnt;
`endif

endmodule

// File: tb/tb_netbus_tx5.sv
// Self-checking bench for netbus_tx5: per-port scoreboard queues filled on input acceptance, drained on output transfer.
module tb_netbus_tx5;

  localparam int unsigned DW = 4;
  localparam int unsigned DL = 1;
  localparam int unsigned FW = DW * 9 + 14;

  logic WCLK = 1'b0;
  logic RESETn;
  always #5 WCLK = ~WCLK;

  netbus_tx5_if #(.FW(FW)) w_if ();
  netbus_tx5_if #(.FW(FW)) t_if0 ();
  netbus_tx5_if #(.FW(FW)) t_if1 ();
  netbus_tx5_if #(.FW(FW)) t_if2 ();
  netbus_tx5_if #(.FW(FW)) t_if3 ();
  netbus_tx5_if #(.FW(FW)) t_if4 ();

  logic [4:0]    t_ready;
  logic [4:0]    tv;
  logic [FW-1:0] td [5];

  assign t_if0.ready = t_ready[0];
  assign t_if1.ready = t_ready[1];
  assign t_if2.ready = t_ready[2];
  assign t_if3.ready = t_ready[3];
  assign t_if4.ready = t_ready[4];
  assign tv = {t_if4.valid, t_if3.valid, t_if2.valid, t_if1.valid, t_if0.valid};
  assign td[0] = t_if0.data;
  assign td[1] = t_if1.data;
  assign td[2] = t_if2.data;
  assign td[3] = t_if3.data;
  assign td[4] = t_if4.data;

`ifdef NETBUS_TX_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic [0:0]  drop_clr;
`endif

  netbus_tx5 #(.DATA_WIDTH(DW), .DEST_LSB(DL)) dut (
    .WCLK   (WCLK),
    .RESETn (RESETn),
    .w      (w_if),
    .t0     (t_if0),
    .t1     (t_if1),
    .t2     (t_if2),
    .t3     (t_if3),
    .t4     (t_if4)
`ifdef NETBUS_TX_DROP_CNT_EN
    ,
    .DROP_CNT (drop_cnt),
    .DROP_CLR (drop_clr)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int last_wait = 0;
  logic [FW-1:0] sb [5][$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [2:0] dest, input logic last);
    logic [FW-1:0] d;
    d = FW'({$urandom(), $urandom()});
    d[DL +: 3] = dest;
    d[0] = last;
    return d;
  endfunction

  function automatic logic [2:0] rnd_dest();
    return 3'($urandom_range(0, 7));
  endfunction

  // Offer one flit until accepted; port < 0 means it is expected to be discarded
  task automatic send(input logic [FW-1:0] d, input int port);
    int n;
    n = 0;
    w_if.valid = 1'b1;
    w_if.data  = d;
    do begin
      @(negedge WCLK);
      n++;
    end while (!w_if.ready && n < 100);
    last_wait = n;
    if (!w_if.ready) begin
      check_eq("accept_timeout", 64'(n), 64'(0));
    end else begin
      acc_cnt++;
      if (port >= 0) sb[port].push_back(d);
    end
    @(posedge WCLK); #1;
    w_if.valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge WCLK);
    #1;
  endtask

  // Output monitor: every transfer must match the head of that port's queue
  always @(negedge WCLK) begin
    if (RESETn) begin
      for (int k = 0; k < 5; k++) begin
        if (tv[k] && t_ready[k]) begin
          check_eq($sformatf("sb_nonempty_p%0d", k), 64'(sb[k].size() != 0), 64'(1));
          if (sb[k].size() != 0)
            check_eq($sformatf("data_p%0d", k), 64'(td[k]), 64'(sb[k].pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] h;
    int base;

    RESETn     = 1'b0;
    w_if.valid = 1'b1;
    w_if.data  = mk(3'd0, 1'b1);
    t_ready    = '1;
`ifdef NETBUS_TX_DROP_CNT_EN
    drop_clr   = 1'b0;
`endif
    cycles(2);
    check_eq("rst_tvalid", 64'(tv), 64'(0));
    for (int k = 0; k < 5; k++) check_eq($sformatf("rst_tdata%0d", k), 64'(td[k]), 64'(0));
    check_eq("rst_wready", 64'(w_if.ready), 64'(0));
    w_if.valid = 1'b0;
    @(negedge WCLK);
    RESETn = 1'b1;
    cycles(3);
    check_eq("idle_tvalid", 64'(tv), 64'(0));
`ifdef NETBUS_TX_DROP_CNT_EN
    check_eq("drop_cnt_rst", 64'(drop_cnt), 64'(0));
`endif

    // 3-flit frame to port 2
    h = mk(3'd2, 1'b0);
    send(h, 2);
    check_eq("lat_vld2", 64'(tv), 64'(5'b00100));
    check_eq("lat_data2", 64'(td[2]), 64'(h));
    send(mk(rnd_dest(), 1'b0), 2);
    send(mk(rnd_dest(), 1'b1), 2);
    cycles(3);
    check_eq("f2_idle", 64'(tv), 64'(0));

    // Backpressure on port 4
    t_ready[4] = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(mk(3'd4, 1'b0), 4);
        for (int i = 0; i < 3; i++) send(mk(rnd_dest(), 1'b0), 4);
        send(mk(rnd_dest(), 1'b1), 4);
      end
    join_none
    cycles(8);
    check_eq("bp_acc", 64'(acc_cnt - base), 64'(2));
    check_eq("bp_wready", 64'(w_if.ready), 64'(0));
    check_eq("bp_vld4", 64'(tv[4]), 64'(1));
    t_ready[4] = 1'b1;
    wait fork;
    cycles(4);
    check_eq("bp_drained", 64'(sb[4].size()), 64'(0));
    check_eq("bp_idle", 64'(tv), 64'(0));

    // Invalid destination frame is swallowed
    send(mk(3'd6, 1'b0), -1);
    check_eq("drop_rdy_h", 64'(last_wait), 64'(1));
    send(mk(rnd_dest(), 1'b0), -1);
    check_eq("drop_rdy_1", 64'(last_wait), 64'(1));
    send(mk(rnd_dest(), 1'b1), -1);
    check_eq("drop_rdy_2", 64'(last_wait), 64'(1));
    cycles(3);
    check_eq("drop_novld", 64'(tv), 64'(0));
`ifdef NETBUS_TX_DROP_CNT_EN
    check_eq("drop_cnt_inc", 64'(drop_cnt), 64'(1));
    drop_clr = 1'b1;
    cycles(1);
    drop_clr = 1'b0;
    check_eq("drop_cnt_clr", 64'(drop_cnt), 64'(0));
`endif

    // Back-to-back frames with port 0 stalled
    t_ready[0] = 1'b0;
    send(mk(3'd0, 1'b1), 0);
    send(mk(3'd3, 1'b0), 3);
    check_eq("b2b_hdr_rdy", 64'(last_wait), 64'(1));
    send(mk(rnd_dest(), 1'b1), 3);
    cycles(3);
    check_eq("b2b_p0_hold", 64'(tv[0]), 64'(1));
    check_eq("b2b_p3_done", 64'(sb[3].size()), 64'(0));
    send(mk(3'd0, 1'b1), 0);
    check_eq("b2b_p0_acc", 64'(last_wait), 64'(1));
    t_ready[0] = 1'b1;
    cycles(4);
    check_eq("b2b_p0_drained", 64'(sb[0].size()), 64'(0));

    // Reset in the middle of a frame to port 1
    t_ready[1] = 1'b0;
    send(mk(3'd1, 1'b0), 1);
    send(mk(rnd_dest(), 1'b0), 1);
    check_eq("mrst_pre_vld1", 64'(tv[1]), 64'(1));
    RESETn = 1'b0;
    #1;
    check_eq("mrst_tvalid", 64'(tv), 64'(0));
    check_eq("mrst_tdata1", 64'(td[1]), 64'(0));
    check_eq("mrst_wready", 64'(w_if.ready), 64'(0));
    for (int k = 0; k < 5; k++) sb[k].delete();
    cycles(1);
    RESETn  = 1'b1;
    t_ready = '1;
    cycles(1);
    send(mk(3'd0, 1'b1), 0);
    cycles(3);
    check_eq("mrst_p0", 64'(sb[0].size()), 64'(0));

    cycles(4);
    for (int k = 0; k < 5; k++) check_eq($sformatf("final_empty_p%0d", k), 64'(sb[k].size()), 64'(0));
    check_eq("final_idle", 64'(tv), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/netbus_tx5.md
Name: netbus_tx5

Overview:
- Single-clock 1-to-5 frame distributor, the transmit-side counterpart of the 5-port NetBus receive merger.
- Accepts one NetBus flit stream and routes each whole frame to one of five output ports.
- The destination comes from the frame's first flit.
- Each output has a 2-entry registered buffer, so output timing is fully registered and frames never interleave on a port.

Parameters:
DATA_WIDTH, 4, NetBus data lanes; flit width is DATA_WIDTH*9+14 bits
DEST_LSB, 1, bit position of the 3-bit destination field in the header flit (field = WDATA[DEST_LSB+2:DEST_LSB])

Ports:
WCLK  input  1  single clock for the whole block
RESETn  input  1  asynchronous active-low reset
WDATA  input  DATA_WIDTH*9+14  input flit; bit 0 = last-flit-of-frame flag
WVALID  input  1  input flit valid
WREADY  output  1  input flit accepted when WVALID & WREADY
TDATAk (k=0..4)  output  DATA_WIDTH*9+14  port k flit
TVALIDk (k=0..4)  output  1  port k flit valid
TREADYk (k=0..4)  input  1  port k downstream ready

Behaviour:
- Reset (async, RESETn low): state=IDLE; all port buffers empty; TVALID0..4=0; TDATA0..4=0. WREADY is combinational and is 0 during reset.
- Flit transfer rule: a flit transfers on WVALID&WREADY at the WCLK rising edge. Output k transfers on TVALIDk&TREADYk.

Port buffer (one per port, 2 entries, FIFO order):
- TVALIDk = not empty. TDATAk = head entry, driven from a register.
- Full = 2 entries. Push and pop in the same cycle are allowed when full; the count is unchanged.
- Latency from input acceptance to TVALIDk is 1 cycle.

State machine:
- IDLE (awaiting header):
  - dest = WDATA[DEST_LSB+2:DEST_LSB].
  - If dest is 0..4: WREADY = !full[dest] | TREADYdest (full entry popping this cycle).
    - On accept, push the flit to port dest and latch cur_port = dest.
    - If WDATA[0]=1 (single-flit frame), stay IDLE; otherwise go to FWD.
  - If dest is 5..7: WREADY = 1 and the flit is discarded.
    - If WDATA[0]=0, go to DROP; otherwise stay IDLE.
- FWD: WREADY = !full[cur_port] | TREADYcur_port.
  - Accepted flits push to cur_port without reading the dest field.
  - An accepted flit with bit 0 = 1 returns the state to IDLE.
- DROP: WREADY = 1 and all flits are discarded. An accepted flit with bit 0 = 1 returns the state to IDLE.

Ordering and isolation:
- Frames to the same port keep arrival order.
- A stalled port blocks only the input stream, never another port's drain. Buffered flits on other ports keep draining.
- Back-to-back frames are allowed: a header may be accepted in the cycle after a last flit, with no bubble.
- WREADY must not depend on WVALID. In IDLE it may depend on WDATA.

Reset mid-frame: the partial frame is lost, buffers are flushed, and the state returns to IDLE. After reset, the next flit is treated as a header.

Optional Feature:
Macro NETBUS_TX_DROP_CNT_EN.
- Defined:
  - Adds output port DROP_CNT [15:0] and input DROP_CLR [0:0].
  - DROP_CNT increments by 1 on each accepted header with dest 5..7 and saturates at 16'hFFFF.
  - DROP_CLR=1 zeroes it synchronously; clear wins over a same-cycle increment.
  - Reset value is 0.
- Undefined: neither port exists and dropped frames are silently discarded.

Test Plan:
- Reset then idle: RESETn=0 → TVALID0..4=0, TDATA0..4=0, state IDLE. Release RESETn, WVALID=0 → outputs stay 0.
- 3-flit frame to port 2: header dest=2, flits A,B,C(bit0=1), TREADY2=1 → TDATA2 shows A,B,C on consecutive cycles starting 1 cycle after each accept. TVALID0,1,3,4 stay 0.
- Backpressure: frame of 5 flits to port 4, TREADY4=0 → exactly 2 flits accepted, then WREADY=0. Raise TREADY4 → remaining 3 flits drain in order with no loss or duplication.
- Invalid dest: header dest=6 plus 2 more flits, last flit bit0=1 → WREADY=1 for all 3, no TVALID asserts. With NETBUS_TX_DROP_CNT_EN defined, DROP_CNT goes 0→1.
- Back-to-back frames: single-flit frame to port 0, then 2-flit frame to port 3, TREADY0=0 → port 0 holds 1 flit and port 3 receives both flits unblocked. A following header to port 0 is accepted (port 0 not full).
- Reset mid-frame: assert RESETn=0 after 2 flits of a 4-flit frame to port 1 → TVALID1=0 immediately. After release, the next flit with dest=0 routes to port 0.
